heap_arbiter: RTL and testbench

//  Shares one heap Memory instance between REQUESTERS clients, round-robin, one op at a time.
//  Per op: drives action/array/index/in, toggles the heap's edge-triggered clock once, captures out/error.

---
 rtl/heap_arbiter.sv | 160 ++++++++++++++++
 tb/tb_heap_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_arbiter.sv
// heap_arbiter: round-robin sharing of one heap Memory between clients.
// Optional ARB_ACTION_CHECK_EN rejects unknown action codes without a heap op.
module heap_arbiter #(
  parameter int REQUESTERS   = 4,
  parameter int ADDRESS_BITS = 2,
  parameter int INDEX_BITS   = 1,
  parameter int DATA_BITS    = 12
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            req,
  input  logic [REQUESTERS*8-1:0]          req_action,
  input  logic [REQUESTERS*ADDRESS_BITS-1:0] req_array,
  input  logic [REQUESTERS*INDEX_BITS-1:0] req_index,
  input  logic [REQUESTERS*DATA_BITS-1:0]  req_in,
  output logic [REQUESTERS-1:0]            done,
  output logic [DATA_BITS-1:0]             rsp_out,
  output logic                             rsp_error,
  output logic                             busy,
  output logic                             heap_clock,
  output logic [7:0]                       heap_action,
  output logic [ADDRESS_BITS-1:0]          heap_array,
  output logic [INDEX_BITS-1:0]            heap_index,
  output logic [DATA_BITS-1:0]             heap_in,
  input  logic [DATA_BITS-1:0]             heap_out,
  input  logic [31:0]                      heap_error
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_INIT_STROBE,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_REJECT
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   gnt_q;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_found;
  logic [PW-1:0]   rr_nxt;
  logic [7:0]      gnt_action;
  logic            reject;

  // First requesting client at or after the round-robin pointer
  always_comb begin
    int k;
    logic [PW-1:0] kk;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    k         = 0;
    kk        = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      k = int'(rr) + i;
      if (k >= REQUESTERS) k = k - REQUESTERS;
      kk = k[PW-1:0];
      if (!gnt_found && req[kk]) begin
        gnt_found = 1'b1;
        gnt_idx   = kk;
      end
    end
  end

  assign gnt_action = req_action[gnt_idx*8 +: 8];
  assign rr_nxt = (gnt_q == PW'(REQUESTERS - 1)) ? '0 : gnt_q + 1'b1;

`ifdef ARB_ACTION_CHECK_EN
  // Only Reset, Write, Read, Size and Greater reach the heap
  always_comb begin
    unique case (gnt_action)
      8'd1, 8'd2, 8'd3, 8'd4, 8'd9: reject = 1'b0;
      default:                      reject = 1'b1;
    endcase
  end
`else
  assign reject = 1'b0;
`endif

  // Sequencer: heap reset on start-up, then one client op at a time
  always_ff @(posedge clock) begin
    done <= '0;
    if (!reset) begin
      state       <= S_INIT;
      rsp_out     <= '0;
      rsp_error   <= 1'b0;
      busy        <= 1'b1;
      heap_clock  <= 1'b0;
      heap_action <= 8'd0;
      heap_array  <= '0;
      heap_index  <= '0;
      heap_in     <= '0;
      rr          <= '0;
      gnt_q       <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          heap_action <= 8'd1;
          state       <= S_INIT_STROBE;
        end
        S_INIT_STROBE: begin
          heap_clock <= ~heap_clock;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        S_IDLE: begin
          if (gnt_found) begin
            gnt_q <= gnt_idx;
            busy  <= 1'b1;
            if (reject) begin
              heap_action <= 8'd0;
              state       <= S_REJECT;
            end else begin
              heap_action <= gnt_action;
              heap_array  <= req_array[gnt_idx*ADDRESS_BITS +: ADDRESS_BITS];
              heap_index  <= req_index[gnt_idx*INDEX_BITS +: INDEX_BITS];
              heap_in     <= req_in[gnt_idx*DATA_BITS +: DATA_BITS];
              state       <= S_SETUP;
            end
          end else begin
            heap_action <= 8'd0;
            busy        <= 1'b0;
          end
        end
        S_SETUP: begin
          state <= S_STROBE;
        end
        S_STROBE: begin
          heap_clock <= ~heap_clock;
          state      <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_out      <= heap_out;
          rsp_error    <= |heap_error;
          done[gnt_q]  <= 1'b1;
          heap_action  <= 8'd0;
          rr           <= rr_nxt;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        S_REJECT: begin
          rsp_out      <= '0;
          rsp_error    <= 1'b1;
          done[gnt_q]  <= 1'b1;
          rr           <= rr_nxt;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// tb_heap_arbiter: scoreboard bench for heap_arbiter with a behavioural heap.
// Build with ARB_ACTION_CHECK_EN defined to exercise the reject path.
module tb_heap_arbiter;

  localparam int R  = 4;
  localparam int AB = 2;
  localparam int IB = 1;
  localparam int DB = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [R-1:0]      req = '0;
  logic [R*8-1:0]    req_action = '0;
  logic [R*AB-1:0]   req_array = '0;
  logic [R*IB-1:0]   req_index = '0;
  logic [R*DB-1:0]   req_in = '0;
  logic [R-1:0]      done;
  logic [DB-1:0]     rsp_out;
  logic              rsp_error;
  logic              busy;
  logic              heap_clock;
  logic [7:0]        heap_action;
  logic [AB-1:0]     heap_array;
  logic [IB-1:0]     heap_index;
  logic [DB-1:0]     heap_in;
  logic [DB-1:0]     heap_out = '0;
  logic [31:0]       heap_error = '0;

  heap_arbiter #(
    .REQUESTERS(R), .ADDRESS_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)
  ) dut (
    .clock(clock), .reset(reset), .req(req),
    .req_action(req_action), .req_array(req_array),
    .req_index(req_index), .req_in(req_in),
    .done(done), .rsp_out(rsp_out), .rsp_error(rsp_error),
    .busy(busy), .heap_clock(heap_clock), .heap_action(heap_action),
    .heap_array(heap_array), .heap_index(heap_index), .heap_in(heap_in),
    .heap_out(heap_out), .heap_error(heap_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // behavioural heap: acts on every heap_clock transition
  logic [DB-1:0] mem [4][2];
  int edges = 0;
  int rst_ops = 0;
  int wr_ops = 0;

  always @(heap_clock) begin
    edges++;
    case (heap_action)
      8'd0: ;
      8'd1: begin
        for (int a = 0; a < 4; a++)
          for (int i = 0; i < 2; i++) mem[a][i] = '0;
        heap_out = '0; heap_error = '0; rst_ops++;
      end
      8'd2: begin
        mem[heap_array][heap_index] = heap_in;
        heap_out = '0; heap_error = '0; wr_ops++;
      end
      8'd3: begin heap_out = mem[heap_array][heap_index]; heap_error = '0; end
      8'd4: begin heap_out = 12'd2; heap_error = '0; end
      8'd9: begin
        heap_out = (heap_in > mem[heap_array][heap_index]) ? 12'd1 : 12'd0;
        heap_error = '0;
      end
      default: begin heap_out = '0; heap_error = 32'd1; end
    endcase
  end

  typedef struct {
    int         client;
    logic [DB-1:0] out;
    logic       err;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int fails = 0;
  int pending [R];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse is matched against the oldest expectation
  always @(negedge clock) begin
    if (done != '0) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", done, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_client", int'(done), 1 << mon_e.client);
        check("rsp_out", int'(rsp_out), int'(mon_e.out));
        check("rsp_error", int'(rsp_error), int'(mon_e.err));
        check("done_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    for (int k = 0; k < R; k++) begin
      if (done[k] && pending[k] > 0) begin
        pending[k]--;
        req[k] = (pending[k] != 0);
      end
    end
  endtask

  task automatic set_client(input int k, input int act, input int arr,
                            input int idx, input int din);
    req_action[k*8 +: 8]   = 8'(act);
    req_array[k*AB +: AB]  = AB'(arr);
    req_index[k*IB +: IB]  = IB'(idx);
    req_in[k*DB +: DB]     = DB'(din);
  endtask

  task automatic expect_done(input int k, input int eout, input int eerr, input int at);
    exp_t e;
    e.client = k;
    e.out = DB'(eout);
    e.err = eerr[0];
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic issue(input int k, input int act, input int arr, input int idx,
                       input int din, input int eout, input int eerr, input int lat);
    set_client(k, act, arr, idx, din);
    pending[k] = 1;
    req[k] = 1'b1;
    expect_done(k, eout, eerr, cyc + lat);
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < R; k++) if (pending[k] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_quiet();
    int n = 0;
    while ((any_pending() || busy || sb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      fails++;
      $display("FAIL timeout: got busy=%0b queued=%0d expected idle", busy, sb.size());
      sb.delete();
      for (int k = 0; k < R; k++) pending[k] = 0;
      req = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int k = 0; k < R; k++) pending[k] = 0;
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    for (int n = 0; n < 10 && busy; n++) tick();
  endtask

  int base_e;
  int base_w;
  int base_r;
  int n0;

  initial begin
    for (int k = 0; k < R; k++) pending[k] = 0;

    // 1: reset state, then a single heap Reset op
    tick();
    check("rst_busy", int'(busy), 1);
    check("rst_done", int'(done), 0);
    check("rst_action", int'(heap_action), 0);
    check("rst_rsp_out", int'(rsp_out), 0);
    tick();
    base_e = edges;
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("init_busy", int'(busy), 0);
    check("init_reset_ops", rst_ops, 1);
    check("init_edges", edges - base_e, 1);
    check("idle_action", int'(heap_action), 0);

    // 2: write then read back
    issue(0, 2, 1, 0, 12'h5A5, 0, 0, 4);
    wait_quiet();
    issue(0, 3, 1, 0, 0, 12'h5A5, 0, 4);
    wait_quiet();

    // 3: all four request Size, rr from 0, client0 twice
    do_reset();
    for (int k = 0; k < R; k++) set_client(k, 4, 0, 0, 0);
    pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
    req = 4'b1111;
    n0 = cyc;
    expect_done(0, 2, 0, n0 + 4);
    expect_done(1, 2, 0, n0 + 8);
    expect_done(2, 2, 0, n0 + 12);
    expect_done(3, 2, 0, n0 + 16);
    expect_done(0, 2, 0, n0 + 20);
    wait_quiet();

    // 4: move rr to 2, then clients 0 and 1 together: wrap to 0 first
    issue(1, 3, 0, 0, 0, 0, 0, 4);
    wait_quiet();
    set_client(0, 2, 3, 1, 12'hABC);
    set_client(1, 3, 3, 1, 0);
    pending[0] = 1; pending[1] = 1;
    req = 4'b0011;
    n0 = cyc;
    expect_done(0, 0, 0, n0 + 4);
    expect_done(1, 12'hABC, 0, n0 + 8);
    wait_quiet();
    issue(2, 9, 3, 1, 12'hFFF, 1, 0, 4);
    wait_quiet();

    // 5: reset during STROBE aborts the write
    set_client(2, 2, 2, 1, 12'h123);
    base_w = wr_ops;
    base_r = rst_ops;
    pending[2] = 1;
    req[2] = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pending[2] = 0;
    req = '0;
    tick();
    check("abort_action", int'(heap_action), 0);
    check("abort_busy", int'(busy), 1);
    check("abort_done", int'(done), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    check("abort_no_write", wr_ops, base_w);
    check("abort_reset_replay", rst_ops, base_r + 1);
    check("abort_idle", int'(busy), 0);
    issue(2, 3, 2, 1, 0, 0, 0, 4);
    wait_quiet();

    // 6: unknown action code
    base_e = edges;
`ifdef ARB_ACTION_CHECK_EN
    issue(3, 20, 0, 0, 0, 0, 1, 2);
    wait_quiet();
    check("bad_action_edges", edges - base_e, 0);
`else
    issue(3, 20, 0, 0, 0, 0, 1, 4);
    wait_quiet();
    check("bad_action_edges", edges - base_e, 1);
`endif

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
